hex_display_ctrl: RTL and testbench

Parametrised seven-segment display controller between the CPU's 32-bit GPIO output register and the board's HEX digits. It latches a packed nibble word on a write strobe and drives NDIGITS active-low segment buses from registers. Per-digit blink runs from an internal prescaler, and optional leading-zero suppression blanks high-order zero digits. An optional time-multiplexed scan output serves boards with a shared segment bus.

---
 rtl/hex_display_ctrl_pkg.sv | 20 ++
 rtl/hex_display_ctrl_if.sv | 28 ++
 rtl/hex_display_ctrl_seg7_decode.sv | 9 +
 rtl/hex_display_ctrl.sv | 127 ++++++++++++
 tb/tb_hex_display_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/hex_display_ctrl_pkg.sv
// Shared types and constants for the seven-segment display controller:
// segment type, blank pattern, glyph table and blink prescaler helper.
package hex_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low gfedcba glyphs for 0-9, A, b, C, d, E, F.
    localparam seg_t GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Terminal count of the blink prescaler (half-period minus one).
    function automatic int prescale_max(input int clk_hz, input int blink_hz);
        return clk_hz / (2 * blink_hz) - 1;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// CPU-side write bus and display-side outputs of hex_display_ctrl.
// The scan outputs exist only when SCAN_EN is defined.
interface hex_display_ctrl_if
    import hex_display_pkg::*;
#(
    parameter int NDIGITS = 8
);
    logic                   wr_en;
    logic [4*NDIGITS-1:0]   wr_data;
    logic                   ctrl_wr;
    logic                   ctrl_lz;
    logic [NDIGITS-1:0]     ctrl_blink;
    logic [7*NDIGITS-1:0]   segs;
`ifdef SCAN_EN
    logic [NDIGITS-1:0]     dig_sel;
    seg_t                   seg_scan;

    modport master (output wr_en, wr_data, ctrl_wr, ctrl_lz, ctrl_blink,
                    input  segs, dig_sel, seg_scan);
    modport slave  (input  wr_en, wr_data, ctrl_wr, ctrl_lz, ctrl_blink,
                    output segs, dig_sel, seg_scan);
`else
    modport master (output wr_en, wr_data, ctrl_wr, ctrl_lz, ctrl_blink,
                    input  segs);
    modport slave  (input  wr_en, wr_data, ctrl_wr, ctrl_lz, ctrl_blink,
                    output segs);
`endif
endinterface

// File: rtl/hex_display_ctrl_seg7_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);
    assign seg = GLYPHS[nibble];
endmodule

// File: rtl/hex_display_ctrl.sv
// Registered seven-segment controller with blink and leading-zero blanking.
// Define SCAN_EN to add the time-multiplexed dig_sel/seg_scan outputs.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NDIGITS  = 8,
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2,
    parameter int SCAN_DIV = 1024
) (
    input  logic               clk,
    input  logic               rst,
    hex_display_ctrl_if.slave  bus
);
    localparam int PRE_MAX = prescale_max(CLK_HZ, BLINK_HZ);
    localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;

    logic [4*NDIGITS-1:0] value;
    logic                 lz;
    logic [NDIGITS-1:0]   blink_mask;
    logic [PRE_W-1:0]     pre;
    logic                 ph;
    logic [7*NDIGITS-1:0] segs_q;
    logic [7*NDIGITS-1:0] segs_next;
    seg_t                 glyph [NDIGITS];
    logic [NDIGITS-1:0]   zero_from;

    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_dec
        seg7_decode u_dec (
            .nibble (value[4*gi +: 4]),
            .seg    (glyph[gi])
        );
    end

    // zero_from[i]: nibbles i..NDIGITS-1 are all zero.
    always_comb begin : lead_zero
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            run          = run & (value[4*i +: 4] == 4'h0);
            zero_from[i] = run;
        end
    end

    always_comb begin
        segs_next = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((ph && blink_mask[i]) || (lz && (i > 0) && zero_from[i]))
                segs_next[7*i +: 7] = SEG_BLANK;
            else
                segs_next[7*i +: 7] = glyph[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value      <= '0;
            lz         <= 1'b0;
            blink_mask <= '0;
            pre        <= '0;
            ph         <= 1'b0;
            segs_q     <= {NDIGITS{GLYPHS[0]}};
        end else begin
            if (bus.wr_en)
                value <= bus.wr_data;
            // A control write restarts the blink in its visible phase.
            if (bus.ctrl_wr) begin
                lz         <= bus.ctrl_lz;
                blink_mask <= bus.ctrl_blink;
                pre        <= '0;
                ph         <= 1'b0;
            end else if (pre == PRE_W'(PRE_MAX)) begin
                pre <= '0;
                ph  <= ~ph;
            end else begin
                pre <= pre + 1'b1;
            end
            segs_q <= segs_next;
        end
    end

    assign bus.segs = segs_q;

`ifdef SCAN_EN
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SCAN_W-1:0]  scan_cnt;
    logic               scan_tc;
    logic [NDIGITS-1:0] dig_q;
    logic [NDIGITS-1:0] dig_next;
    seg_t               scan_q;
    seg_t               scan_next;

    assign scan_tc = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // seg_scan follows the next selection so it always matches dig_sel.
    always_comb begin
        dig_next  = dig_q;
        scan_next = SEG_BLANK;
        if (scan_tc) begin
            for (int i = 0; i < NDIGITS; i++)
                dig_next[(i + 1) % NDIGITS] = dig_q[i];
        end
        for (int i = 0; i < NDIGITS; i++) begin
            if (dig_next[i])
                scan_next = segs_next[7*i +: 7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_q    <= NDIGITS'(1);
            scan_q   <= GLYPHS[0];
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
            dig_q    <= dig_next;
            scan_q   <= scan_next;
        end
    end

    assign bus.dig_sel  = dig_q;
    assign bus.seg_scan = scan_q;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (8 digits, 8 Hz clock,
// 1 Hz blink); scan checks are included when SCAN_EN is defined.
module tb_hex_display_ctrl;
    localparam int NDIGITS = 8;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    hex_display_ctrl_if #(.NDIGITS(NDIGITS)) bus ();

    hex_display_ctrl #(
        .NDIGITS  (NDIGITS),
        .CLK_HZ   (8),
        .BLINK_HZ (1),
        .SCAN_DIV (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] dig(input int i);
        return bus.segs[7*i +: 7];
    endfunction

    localparam logic [6:0] SCAN_GLYPH [8] = '{7'h21, 7'h46, 7'h03, 7'h08,
                                              7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        logic [6:0] exp_seg;
        n_chk          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_data    = '0;
        bus.ctrl_wr    = 1'b0;
        bus.ctrl_lz    = 1'b0;
        bus.ctrl_blink = '0;

        tick();
        tick();
        check("reset_segs", bus.segs, {8{7'h40}});
`ifdef SCAN_EN
        check("reset_dig_sel", bus.dig_sel, 8'h01);
        check("reset_seg_scan", bus.seg_scan, 7'h40);
`endif
        rst = 1'b0;

        // write latency
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'h1234ABCD;
        tick();
        bus.wr_en = 1'b0;
        check("write_early_d0", dig(0), 7'h40);
        tick();
        check("write_d0", dig(0), 7'h21);
        check("write_d1", dig(1), 7'h46);
        check("write_d4", dig(4), 7'h19);
        check("write_d7", dig(7), 7'h79);

        // leading-zero suppression
        bus.ctrl_wr    = 1'b1;
        bus.ctrl_lz    = 1'b1;
        bus.ctrl_blink = 8'h00;
        bus.wr_en      = 1'b1;
        bus.wr_data    = 32'h0000_00F0;
        tick();
        bus.ctrl_wr = 1'b0;
        bus.wr_en   = 1'b0;
        tick();
        for (int i = 0; i < NDIGITS; i++) begin
            exp_seg = (i >= 2) ? 7'h7F : (i == 1) ? 7'h0E : 7'h40;
            check($sformatf("lz_f0_d%0d", i), dig(i), exp_seg);
        end
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'h0;
        tick();
        bus.wr_en = 1'b0;
        tick();
        for (int i = 0; i < NDIGITS; i++) begin
            exp_seg = (i == 0) ? 7'h40 : 7'h7F;
            check($sformatf("lz_zero_d%0d", i), dig(i), exp_seg);
        end

        // simultaneous value and control write
        bus.ctrl_wr = 1'b1;
        bus.ctrl_lz = 1'b0;
        tick();
        bus.ctrl_lz = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'h0000_0005;
        tick();
        bus.ctrl_wr = 1'b0;
        bus.wr_en   = 1'b0;
        tick();
        check("both_d0", dig(0), 7'h12);
        for (int i = 1; i < NDIGITS; i++)
            check($sformatf("both_d%0d", i), dig(i), 7'h7F);

        // blink: 4 visible, 4 blank on digit 0 only
        bus.ctrl_wr    = 1'b1;
        bus.ctrl_lz    = 1'b0;
        bus.ctrl_blink = 8'h01;
        bus.wr_en      = 1'b1;
        bus.wr_data    = 32'h0000_0007;
        tick();
        bus.ctrl_wr = 1'b0;
        bus.wr_en   = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_seg = (((k - 1) / 4) % 2 == 1) ? 7'h7F : 7'h78;
            check($sformatf("blink_d0_k%0d", k), dig(0), exp_seg);
            check($sformatf("blink_d1_k%0d", k), dig(1), 7'h40);
        end

        // restart mid-blank
        bus.ctrl_wr = 1'b1;
        tick();
        bus.ctrl_wr = 1'b0;
        check("restart_k0", dig(0), 7'h7F);
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_seg = (k <= 4) ? 7'h78 : 7'h7F;
            check($sformatf("restart_k%0d", k), dig(0), exp_seg);
        end

        // reset during blank phase
        rst = 1'b1;
        tick();
        check("rst_mid_blink", bus.segs, {8{7'h40}});
        rst = 1'b0;
        tick();
        check("post_rst_segs", bus.segs, {8{7'h40}});

`ifdef SCAN_EN
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'h1234ABCD;
        for (int k = 1; k <= 18; k++) begin
            tick();
            bus.wr_en = 1'b0;
            check($sformatf("scan_sel_k%0d", k), bus.dig_sel, 8'h01 << ((k / 2) % 8));
            if (k >= 2)
                check($sformatf("scan_seg_k%0d", k), bus.seg_scan, SCAN_GLYPH[(k / 2) % 8]);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("scan_rst_sel", bus.dig_sel, 8'h01);
        check("scan_rst_seg", bus.seg_scan, 7'h40);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
